// File: rtl/montre_sysid_checker.sv
// montre_sysid_checker
//   Boot-time sysid checker. After reset it reads the system ID (address 0) and the
//   build timestamp (address 1) over an Avalon-MM read master. Both words are compared
//   against build-time constants, and match, mismatch or timeout is reported to the watch
//   control logic. The captured words are held for debug. A start pulse reruns the check.
//
//   Build option: define SYSID_CHECK_RETRY_EN to rerun the whole sequence on a mismatch,
//   up to MAX_RETRIES extra times, before reporting the result.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | parked; reached only when start is high in the last reset cycle
//   RD_ID | reading the ID word (address 0)
//   RD_TS | reading the timestamp word (address 1)
//   CMP   | one cycle in which the captured words are compared
//   DONE  | results valid and held until the next start

module montre_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h00000000,
  parameter logic [31:0] EXPECTED_TS    = 32'h653AF4AD,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_ID = 3'd1;
  localparam logic [2:0] RD_TS = 3'd2;
  localparam logic [2:0] CMP   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Last wait-counter value tolerated while the slave is still stalling.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Settings outside the supported ranges land in this empty block. That makes them
  // visible in the elaborated hierarchy.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 ||
      MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_param_out_of_range
  end

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] wait_cnt;
  logic        in_read;
  logic        rd_accept;
  logic        rd_expire;
  logic        start_go;
  logic        id_ok_nxt;
  logic        ts_ok_nxt;
  logic        retry_take;

  assign in_read   = (state == RD_ID) || (state == RD_TS);
  assign rd_accept = in_read && !avm_waitrequest;
  assign rd_expire = in_read && avm_waitrequest && (wait_cnt == WAIT_LAST);
  assign start_go  = start && ((state == IDLE) || (state == DONE));
  assign id_ok_nxt = (captured_id == EXPECTED_ID);
  assign ts_ok_nxt = (captured_ts == EXPECTED_TS);

`ifdef SYSID_CHECK_RETRY_EN
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  logic [3:0] retry_cnt;

  // A timeout never retries. Only a completed compare with a mismatch loops back.
  assign retry_take = (state == CMP) && (!id_ok_nxt || !ts_ok_nxt) &&
                      (retry_cnt < RETRY_LIMIT);

  // Retry budget: restored on reset and on every accepted start, spent on each loop-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      retry_cnt <= 4'd0;
    end else if (start_go) begin
      retry_cnt <= 4'd0;
    end else if (retry_take) begin
      retry_cnt <= retry_cnt + 4'd1;
    end
  end
`else
  assign retry_take = 1'b0;
`endif

  // Next-state decode. Start is honoured only while parked, so a start pulse while busy is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RD_ID;
      end
      RD_ID: begin
        if (!avm_waitrequest) state_nxt = RD_TS;
        else if (rd_expire)   state_nxt = DONE;
      end
      RD_TS: begin
        if (!avm_waitrequest) state_nxt = CMP;
        else if (rd_expire)   state_nxt = DONE;
      end
      CMP: begin
        state_nxt = retry_take ? RD_ID : DONE;
      end
      DONE: begin
        if (start) state_nxt = RD_ID;
      end
      default: state_nxt = RD_ID;
    endcase
  end

  // State register. Reset parks in RD_ID so that the check runs on its own after release.
  // A start seen in the last reset cycle parks in IDLE instead.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= start ? IDLE : RD_ID;
    end else begin
      state <= state_nxt;
    end
  end

  // Per-read stall counter. It counts consecutive waitrequest cycles and clears on any accepted read.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= 16'd0;
    end else if (in_read && avm_waitrequest && !rd_expire) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= 16'd0;
    end
  end

  // Capture registers. They only change when a read completes, so a timeout or restart leaves them alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
    end else begin
      if ((state == RD_ID) && rd_accept) captured_id <= avm_readdata;
      if ((state == RD_TS) && rd_accept) captured_ts <= avm_readdata;
    end
  end

  // Result flags. They clear on an accepted start and are set by either a timeout or the compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      done    <= 1'b0;
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      timeout <= 1'b0;
    end else if (start_go) begin
      done    <= 1'b0;
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      timeout <= 1'b0;
    end else if (rd_expire) begin
      done    <= 1'b1;
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      timeout <= 1'b1;
    end else if ((state == CMP) && !retry_take) begin
      done    <= 1'b1;
      id_ok   <= id_ok_nxt;
      ts_ok   <= ts_ok_nxt;
    end
  end

  // Bus strobes and busy are decoded from the state. They are masked while reset is high so that
  // every output is 0 during reset, even though the state register already holds RD_ID.
  assign avm_read    = in_read && !reset;
  assign avm_address = (state == RD_TS) && !reset;
  assign busy        = (in_read || (state == CMP)) && !reset;

endmodule

// File: tb/tb_montre_sysid_checker.sv
// Directed bench for montre_sysid_checker with default parameters. A small Avalon slave model
// returns id_val/ts_val and can stall each read for a programmable number of cycles, or forever.
module tb_montre_sysid_checker;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] captured_id;
  logic [31:0] captured_ts;

  logic [31:0] id_val;
  logic [31:0] ts_val;
  logic        hold_wait;
  int          stall_cfg;
  int          stall_left;
  int          id_reads;

  int total = 0;
  int bad   = 0;

  montre_sysid_checker dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .captured_id     (captured_id),
    .captured_ts     (captured_ts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave model.
  assign avm_readdata    = avm_address ? ts_val : id_val;
  assign avm_waitrequest = hold_wait | (avm_read & (stall_left > 0));

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_left <= stall_left - 1;
    else                             stall_left <= stall_cfg;
    if (avm_read && !avm_waitrequest && !avm_address) id_reads <= id_reads + 1;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The current cycle counts as 1. Returns the cycle number in which done is first seen high.
  task automatic wait_done(input int max_c, output int n);
    n = 1;
    while (done !== 1'b1 && n < max_c) begin
      cyc();
      n++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
  endtask

  int n;
  int base;
  int hi;

  initial begin
    reset = 1'b1; start = 1'b0; hold_wait = 1'b0; stall_cfg = 0; stall_left = 0; id_reads = 0;
    id_val = 32'h0000_0000; ts_val = 32'h653A_F4AD;

    // Reset state.
    repeat (3) cyc();
    chk("rst_read",    {31'd0, avm_read}, 32'd0);
    chk("rst_busy",    {31'd0, busy},     32'd0);
    chk("rst_done",    {31'd0, done},     32'd0);
    chk("rst_id_ok",   {31'd0, id_ok},    32'd0);
    chk("rst_timeout", {31'd0, timeout},  32'd0);
    chk("rst_cap_ts",  captured_ts,       32'd0);

    // 1: zero-wait auto-run, done in cycle 4.
    base = id_reads;
    reset = 1'b0;
    #1;
    chk("t1_read_c1", {31'd0, avm_read},    32'd1);
    chk("t1_addr_c1", {31'd0, avm_address}, 32'd0);
    chk("t1_busy_c1", {31'd0, busy},        32'd1);
    cyc();
    chk("t1_addr_c2", {31'd0, avm_address}, 32'd1);
    wait_done(20, n);
    chk("t1_latency", n, 32'd3);  // already one cycle in; cycle 4 overall
    chk("t1_id_ok",   {31'd0, id_ok},   32'd1);
    chk("t1_ts_ok",   {31'd0, ts_ok},   32'd1);
    chk("t1_timeout", {31'd0, timeout}, 32'd0);
    chk("t1_busy",    {31'd0, busy},    32'd0);
    chk("t1_read",    {31'd0, avm_read}, 32'd0);
    chk("t1_cap_ts",  captured_ts, 32'h653A_F4AD);
    chk("t1_id_reads", id_reads - base, 32'd1);

    // 5a: start in DONE drops done the next cycle and reasserts it 4 cycles after the start.
    pulse_start();
    chk("t5_done_drop", {31'd0, done}, 32'd0);
    chk("t5_busy",      {31'd0, busy}, 32'd1);
    chk("t5_id_ok_clr", {31'd0, id_ok}, 32'd0);
    wait_done(20, n);
    chk("t5_restart_lat", n, 32'd4);

    // 5b: start during RD_TS is ignored, and there is no queued rerun.
    base = id_reads;
    pulse_start();             // now in RD_ID
    cyc();                     // now in RD_TS
    chk("t5_in_rd_ts", {31'd0, avm_address}, 32'd1);
    pulse_start();             // start sampled in RD_TS; now in CMP
    wait_done(20, n);
    chk("t5_ign_lat", n, 32'd2);
    repeat (3) cyc();
    chk("t5_still_done", {31'd0, done}, 32'd1);
    chk("t5_no_rerun",   {31'd0, busy}, 32'd0);
    chk("t5_one_seq",    id_reads - base, 32'd1);

    // 2: timestamp off by one.
    ts_val = 32'h653A_F4AC;
    base = id_reads;
    pulse_start();
    wait_done(60, n);
`ifdef SYSID_CHECK_RETRY_EN
    chk("t2_latency",  n, 32'd13);
    chk("t2_id_reads", id_reads - base, 32'd4);
`else
    chk("t2_latency",  n, 32'd4);
    chk("t2_id_reads", id_reads - base, 32'd1);
`endif
    chk("t2_id_ok",   {31'd0, id_ok},   32'd1);
    chk("t2_ts_ok",   {31'd0, ts_ok},   32'd0);
    chk("t2_timeout", {31'd0, timeout}, 32'd0);
    chk("t2_cap_ts",  captured_ts, 32'h653A_F4AC);

    // ID mismatch with a correct timestamp.
    ts_val = 32'h653A_F4AD;
    id_val = 32'h1234_5678;
    pulse_start();
    wait_done(60, n);
`ifdef SYSID_CHECK_RETRY_EN
    chk("tid_latency", n, 32'd13);
`else
    chk("tid_latency", n, 32'd4);
`endif
    chk("tid_id_ok",  {31'd0, id_ok}, 32'd0);
    chk("tid_ts_ok",  {31'd0, ts_ok}, 32'd1);
    chk("tid_cap_id", captured_id, 32'h1234_5678);

    // 3: stalled slave. Read is held high for 16 cycles, then the checker times out and keeps the captures.
    id_val = 32'hDEAD_BEEF;
    hold_wait = 1'b1;
    pulse_start();
    hi = 0;
    while (avm_read === 1'b1 && hi < 40) begin
      hi++;
      cyc();
    end
    chk("t3_read_cycles", hi, 32'd16);
    chk("t3_done",    {31'd0, done},    32'd1);
    chk("t3_timeout", {31'd0, timeout}, 32'd1);
    chk("t3_id_ok",   {31'd0, id_ok},   32'd0);
    chk("t3_ts_ok",   {31'd0, ts_ok},   32'd0);
    chk("t3_busy",    {31'd0, busy},    32'd0);
    chk("t3_cap_id_kept", captured_id, 32'h1234_5678);

    // A start clears timeout.
    hold_wait = 1'b0;
    id_val = 32'h0000_0000;
    pulse_start();
    chk("t3_timeout_clr", {31'd0, timeout}, 32'd0);
    wait_done(20, n);
    chk("t3_recover_lat", n, 32'd4);
    chk("t3_recover_ok",  {31'd0, id_ok & ts_ok}, 32'd1);

    // 4: three stall cycles on each read, done in cycle 10 after reset.
    stall_cfg = 3;
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    wait_done(40, n);
    chk("t4_latency", n, 32'd10);
    chk("t4_cap_id",  captured_id, 32'h0000_0000);
    chk("t4_cap_ts",  captured_ts, 32'h653A_F4AD);
    chk("t4_timeout", {31'd0, timeout}, 32'd0);
    chk("t4_ok",      {31'd0, id_ok & ts_ok}, 32'd1);
    stall_cfg = 0;
    cyc();

    // 6: reset during a stalled RD_TS.
    pulse_start();             // RD_ID
    cyc();                     // RD_TS
    hold_wait = 1'b1;
    reset = 1'b1;
    cyc();
    chk("t6_read",   {31'd0, avm_read}, 32'd0);
    chk("t6_busy",   {31'd0, busy},     32'd0);
    chk("t6_cap_ts", captured_ts,       32'd0);
    hold_wait = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_rerun_addr", {30'd0, avm_read, avm_address}, 32'd2);
    wait_done(20, n);
    chk("t6_latency", n, 32'd4);
    chk("t6_ok", {31'd0, id_ok & ts_ok}, 32'd1);

    // Start during the last reset cycle parks the checker in IDLE until the next start.
    reset = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    reset = 1'b0;
    start = 1'b0;
    #1;
    repeat (3) cyc();
    chk("idle_read", {31'd0, avm_read}, 32'd0);
    chk("idle_busy", {31'd0, busy},     32'd0);
    chk("idle_done", {31'd0, done},     32'd0);
    pulse_start();
    chk("idle_go", {31'd0, avm_read}, 32'd1);
    wait_done(20, n);
    chk("idle_latency", n, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
